// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int FETCH_ADDR_W = 32;
    localparam int FETCH_DATA_W = 32;

    localparam logic [FETCH_ADDR_W-1:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam logic [FETCH_DATA_W-1:0] INSTR_NOP        = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO with flush; used both for fetched words and for
// the PCs of requests still waiting on memory.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  entry_t                       push_data,
    input  logic                         pop,
    input  logic                         flush,
    output entry_t                       pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop & ~empty & ~flush;
        do_push  = push & ~flush & (~full | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns PCF, issues in-order memory requests under a credit limit,
// buffers returned words for decode and discards wrong-path responses on redirect.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int                    BUF_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  PCSrc,
    input  logic [ADDR_WIDTH-1:0] PCTarget,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  DecodeReady,
    output logic                  InstrValidD,
    output logic [DATA_WIDTH-1:0] InstrD,
    output logic [ADDR_WIDTH-1:0] PCD,
    output logic [ADDR_WIDTH-1:0] PCPlus4D
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pcf_q, pcf_d;
    logic [CNT_W-1:0]      outstanding_q, outstanding_d;
    logic [CNT_W-1:0]      discard_q, discard_d;
    logic [CNT_W:0]        credit_used;
    logic                  grant, rsp, keep, pop;
    fetch_entry_t          push_entry, head_entry;
    logic [ADDR_WIDTH-1:0] req_pc;
    logic                  buf_empty, buf_full, addr_empty, addr_full;
    logic [CNT_W-1:0]      buf_count, addr_count;
    logic                  unused_status;

    // Credits cover in-flight requests too, so the word buffer can never overflow.
    assign credit_used = {1'b0, outstanding_q} + {1'b0, buf_count};
    assign imem_req    = (state_q == FETCH) && (credit_used < (CNT_W+1)'(BUF_DEPTH));
    assign imem_addr   = pcf_q;
    assign grant       = imem_req & imem_gnt;
    assign rsp         = imem_rvalid & (outstanding_q != '0);
    assign keep        = rsp & (discard_q == '0);

    assign InstrValidD = ~buf_empty & ~PCSrc;
    assign pop         = InstrValidD & DecodeReady;
    assign push_entry  = '{pc: req_pc, instr: imem_rdata};
    assign InstrD      = buf_empty ? INSTR_NOP : head_entry.instr;
    assign PCD         = buf_empty ? RESET_PC  : head_entry.pc;
    assign PCPlus4D    = PCD + ADDR_WIDTH'(4);

    assign unused_status = ^{buf_full, addr_empty, addr_full, addr_count};

    fetch_buffer #(
        .DEPTH   (BUF_DEPTH),
        .entry_t (logic [ADDR_WIDTH-1:0])
    ) u_addr_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (grant),
        .push_data (pcf_q),
        .pop       (keep),
        .flush     (PCSrc),
        .pop_data  (req_pc),
        .full      (addr_full),
        .empty     (addr_empty),
        .count     (addr_count)
    );

    fetch_buffer #(
        .DEPTH   (BUF_DEPTH),
        .entry_t (fetch_entry_t)
    ) u_instr_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (keep),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (PCSrc),
        .pop_data  (head_entry),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    always_comb begin
        outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(rsp);
        discard_d     = discard_q;
        pcf_d         = pcf_q;
        state_d       = state_q;
        if (rsp && discard_q != '0) discard_d = discard_q - 1'b1;
        if (grant) pcf_d = pcf_q + ADDR_WIDTH'(4);
        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   state_d = FETCH;
            DRAIN:   if (discard_q == '0) state_d = FETCH;
            default: state_d = IDLE;
        endcase
        // Redirect overrides everything: anything still in flight becomes wrong-path.
        if (PCSrc) begin
            pcf_d     = {PCTarget[ADDR_WIDTH-1:2], 2'b00};
            discard_d = outstanding_d;
            state_d   = (outstanding_d != '0) ? DRAIN : FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pcf_q         <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            pcf_q         <= pcf_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    a_no_spurious_rvalid: assert property (
        @(posedge clk) disable iff (!rst_n) imem_rvalid |-> (outstanding_q != '0)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a memory model answers requests, expected
// instructions are queued by the stimulus and a monitor checks each delivery.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        DecodeReady;
    logic        InstrValidD;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;

    fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .PCSrc       (PCSrc),
        .PCTarget    (PCTarget),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .DecodeReady (DecodeReady),
        .InstrValidD (InstrValidD),
        .InstrD      (InstrD),
        .PCD         (PCD),
        .PCPlus4D    (PCPlus4D)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] pc4; } exp_t;
    typedef struct { logic [31:0] addr; int due; } pend_t;

    int          compared   = 0;
    int          mismatched = 0;
    exp_t        exp_q[$];
    pend_t       pend_q[$];
    logic [31:0] issued_q[$];
    int          budget    = 0;
    int          lat_mode  = 0;
    int          fixed_lat = 1;
    int          grants    = 0;
    int          cyc       = 0;
    int          last_due  = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic expect_instr(input logic [31:0] pc, input logic [31:0] pc4);
        exp_q.push_back('{pc, pc4});
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || pend_q.size() != 0) && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s: timed out with %0d instructions still expected", name, exp_q.size());
            exp_q.delete();
        end
        repeat (3) step();
    endtask

    task automatic wait_grants(input int target, input string name);
        int n = 0;
        while (grants < target && n < 50) begin
            step();
            n++;
        end
        if (grants < target) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s: grants %0d, required %0d", name, grants, target);
        end
    endtask

    task automatic apply_reset();
        rst_n  = 1'b0;
        budget = 0;
        PCSrc  = 1'b0;
        repeat (2) step();
        rst_n  = 1'b1;
    endtask

    // One-cycle redirect pulse; decode must never see a valid in that cycle.
    task automatic apply_stimulus(input logic [31:0] target);
        PCSrc    = 1'b1;
        PCTarget = target;
        #1;
        check_output("valid_low_on_redirect", 32'(InstrValidD), 32'd0);
        step();
        PCSrc = 1'b0;
    endtask

    task automatic check_last_issued(input string name, input int back, input logic [31:0] expected);
        if (issued_q.size() < back) check_output(name, 32'hXXXX_XXXX, expected);
        else check_output(name, issued_q[issued_q.size() - back], expected);
    endtask

    // Memory model: always in order, grants limited by budget, latency 1..4.
    initial begin
        int lat;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                pend_q.delete();
                last_due    = 0;
                imem_gnt    = 1'b0;
                imem_rvalid = 1'b0;
                continue;
            end
            imem_rvalid = 1'b0;
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend_q[0].addr);
                void'(pend_q.pop_front());
            end
            imem_gnt = (budget > 0);
            if (imem_req && budget > 0) begin
                budget--;
                grants++;
                issued_q.push_back(imem_addr);
                lat = (lat_mode != 0) ? int'($urandom_range(4, 1)) : fixed_lat;
                if (cyc + lat <= last_due) last_due = last_due + 1;
                else last_due = cyc + lat;
                pend_q.push_back('{imem_addr, last_due});
            end
        end
    end

    // Monitor: every instruction decode accepts is compared against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (rst_n && InstrValidD && DecodeReady) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_valid: got PCD %h, expected no instruction", PCD);
                end else begin
                    e = exp_q.pop_front();
                    check_output("PCD", PCD, e.pc);
                    check_output("InstrD", InstrD, mem_word(e.pc));
                    check_output("PCPlus4D", PCPlus4D, e.pc4);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got %0d compared", compared);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int first;
        int g;
        rst_n       = 1'b0;
        PCSrc       = 1'b0;
        PCTarget    = '0;
        DecodeReady = 1'b1;
        repeat (2) step();
        #1;
        check_output("rst_req", 32'(imem_req), 32'd0);
        check_output("rst_valid", 32'(InstrValidD), 32'd0);
        check_output("rst_instr", InstrD, 32'h0000_0013);
        check_output("rst_pcd", PCD, 32'hBFC0_0000);
        check_output("rst_pc4", PCPlus4D, 32'hBFC0_0004);
        check_output("rst_addr", imem_addr, 32'hBFC0_0000);

        // Straight-line fetch, 1-cycle memory
        budget = 6;
        for (int i = 0; i < 6; i++) expect_instr(32'hBFC0_0000 + 32'(4 * i), 32'hBFC0_0004 + 32'(4 * i));
        step();
        rst_n = 1'b1;
        #1;
        check_output("no_req_first_cycle", 32'(imem_req), 32'd0);
        first = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            #1;
            if (InstrValidD && first == 0) begin
                first = k;
                check_output("first_pcd", PCD, 32'hBFC0_0000);
                check_output("first_pc4", PCPlus4D, 32'hBFC0_0004);
            end
        end
        check_output("first_valid_cycle", 32'(first), 32'd3);
        wait_idle("straight_fetch");
        check_output("issued_count", 32'(issued_q.size()), 32'd6);
        for (int i = 0; i < 6; i++) check_output("issued_addr", issued_q[i], 32'hBFC0_0000 + 32'(4 * i));

        // Decode stalled: credits stop requests at two
        DecodeReady = 1'b0;
        g = grants;
        budget = 6;
        for (int i = 0; i < 6; i++) expect_instr(32'hBFC0_0018 + 32'(4 * i), 32'hBFC0_001C + 32'(4 * i));
        repeat (10) step();
        #1;
        check_output("stall_grants", 32'(grants - g), 32'd2);
        check_output("stall_req_low", 32'(imem_req), 32'd0);
        DecodeReady = 1'b1;
        wait_idle("stall_release");

        // Variable latency, then redirect with two requests in flight
        lat_mode = 1;
        budget = 4;
        for (int i = 0; i < 4; i++) expect_instr(32'hBFC0_0030 + 32'(4 * i), 32'hBFC0_0034 + 32'(4 * i));
        wait_idle("var_latency");
        lat_mode = 0;
        fixed_lat = 4;
        g = grants;
        budget = 2;
        wait_grants(g + 2, "inflight_grants");
        step();
        apply_stimulus(32'h8000_0102);
        #1;
        check_output("drain_req_low", 32'(imem_req), 32'd0);
        check_output("redirect_addr", imem_addr, 32'h8000_0100);
        wait_idle("drain_discard");
        check_output("discarded_no_valid", 32'(InstrValidD), 32'd0);
        fixed_lat = 1;
        expect_instr(32'h8000_0100, 32'h8000_0104);
        budget = 1;
        wait_idle("after_redirect");
        check_last_issued("redirect_issued", 1, 32'h8000_0100);

        // Redirect coincident with a grant at BFC00008
        DecodeReady = 1'b0;
        apply_reset();
        g = grants;
        budget = 2;
        wait_grants(g + 2, "refill_grants");
        wait_idle("refill");
        #1;
        check_output("full_valid", 32'(InstrValidD), 32'd1);
        check_output("full_head", PCD, 32'hBFC0_0000);
        expect_instr(32'hBFC0_0000, 32'hBFC0_0004);
        step();
        DecodeReady = 1'b1;
        step();
        DecodeReady = 1'b0;
        #1;
        check_output("held_head", PCD, 32'hBFC0_0004);
        check_output("held_req", 32'(imem_req), 32'd1);
        check_output("held_addr", imem_addr, 32'hBFC0_0008);
        budget = 1;
        step();
        apply_stimulus(32'h0000_4001);
        #1;
        check_output("gnt_redirect_addr", imem_addr, 32'h0000_4000);
        wait_idle("gnt_redirect_drain");
        check_output("flushed_no_valid", 32'(InstrValidD), 32'd0);
        DecodeReady = 1'b1;
        expect_instr(32'h0000_4000, 32'h0000_4004);
        budget = 1;
        wait_idle("gnt_redirect_target");
        check_last_issued("discarded_grant_addr", 2, 32'hBFC0_0008);
        check_last_issued("target_issued", 1, 32'h0000_4000);

        // PC wrap-around
        apply_stimulus(32'hFFFF_FFFE);
        #1;
        check_output("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        expect_instr(32'hFFFF_FFFC, 32'h0000_0000);
        expect_instr(32'h0000_0000, 32'h0000_0004);
        budget = 2;
        wait_idle("wrap");
        check_last_issued("wrap_issued_hi", 2, 32'hFFFF_FFFC);
        check_last_issued("wrap_issued_lo", 1, 32'h0000_0000);

        // Reset while the buffer is full
        DecodeReady = 1'b0;
        g = grants;
        budget = 2;
        wait_grants(g + 2, "burst_grants");
        wait_idle("burst_fill");
        #1;
        check_output("burst_full_req", 32'(imem_req), 32'd0);
        check_output("burst_full_valid", 32'(InstrValidD), 32'd1);
        rst_n = 1'b0;
        budget = 0;
        #1;
        check_output("midrst_valid", 32'(InstrValidD), 32'd0);
        check_output("midrst_instr", InstrD, 32'h0000_0013);
        check_output("midrst_pcd", PCD, 32'hBFC0_0000);
        check_output("midrst_pc4", PCPlus4D, 32'hBFC0_0004);
        check_output("midrst_addr", imem_addr, 32'hBFC0_0000);
        repeat (2) step();
        rst_n = 1'b1;
        DecodeReady = 1'b1;
        expect_instr(32'hBFC0_0000, 32'hBFC0_0004);
        budget = 1;
        wait_idle("restart");
        check_last_issued("restart_addr", 1, 32'hBFC0_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of decode and control_unit.
- Owns the PC register and issues in-order requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned words with their PCs and presents them to decode under a valid/ready handshake.
- Consumes PCSrc and PCTarget, which the control unit and execute stage produce, to redirect fetch and discard wrong-path instructions.

Parameters:
- DATA_WIDTH, 32, instruction word width.
- ADDR_WIDTH, 32, PC and memory address width.
- RESET_PC, 32'hBFC00000, PC value loaded on reset.
- BUF_DEPTH, 2, fetch buffer entries; also the maximum number of requests in flight plus buffered entries.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- PCSrc  in  1  redirect strobe from control_unit; one-cycle pulse.
- PCTarget  in  ADDR_WIDTH  redirect target address.
- imem_req  out  1  fetch request valid.
- imem_addr  out  ADDR_WIDTH  fetch address; always equals PCF.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  read data valid; responses return in order, at least 1 cycle after gnt.
- imem_rdata  in  DATA_WIDTH  returned instruction.
- DecodeReady  in  1  decode can accept an instruction.
- InstrValidD  out  1  InstrD, PCD and PCPlus4D are valid.
- InstrD  out  DATA_WIDTH  instruction to decode.
- PCD  out  ADDR_WIDTH  PC of InstrD.
- PCPlus4D  out  ADDR_WIDTH  PCD + 4.

Behaviour:
- Reset (async assert, rst_n=0):
  - PCF = RESET_PC; state = IDLE; outstanding = 0; discard = 0; buffer empty.
  - imem_req = 0; InstrValidD = 0; InstrD = 32'h00000013 (NOP); PCD = RESET_PC; PCPlus4D = RESET_PC+4.
- FSM, fetch_state_t:
  - IDLE: one cycle after reset release, no request. Always goes to FETCH.
  - FETCH: imem_req = 1 when outstanding + occupancy < BUF_DEPTH.
  - DRAIN: imem_req = 0. Returns to FETCH in the cycle after discard reaches 0.
- Grant: when imem_req & imem_gnt, PCF <= PCF+4 and outstanding increments. An address FIFO (BUF_DEPTH deep) records PCF for each issued request.
- Response: when imem_rvalid, outstanding decrements.
  - If discard > 0: discard decrements and the word is dropped.
  - Otherwise {PC, rdata} is pushed into the buffer.
  - Latency from rvalid to InstrValidD is 1 cycle; there is no bypass.
- Output: InstrValidD = buffer non-empty & ~PCSrc.
  - The buffer pops on InstrValidD & DecodeReady.
  - Outputs are driven from the buffer head.
- Redirect (PCSrc=1):
  - PCF <= {PCTarget[ADDR_WIDTH-1:2], 2'b00}; misaligned low bits are silently cleared.
  - Buffer and address FIFO are flushed.
  - discard <= outstanding after this cycle's grant/response updates.
  - Next state is DRAIN if that value is > 0, else FETCH.
- Simultaneous events:
  - Redirect wins over a same-cycle grant: the granted request counts as outstanding and is discarded, and PCF takes the target, not +4.
  - Redirect wins over a same-cycle pop: nothing is consumed.
  - A redirect while in DRAIN reloads PCF; the discard count carries over.
  - rvalid and gnt in the same cycle: outstanding is unchanged.
- Full buffer: imem_req is held low. The buffer never overflows, because credit accounting includes in-flight requests.
- Arithmetic: all PC math is mod 2^ADDR_WIDTH, so PCF = FFFF_FFFC wraps to 0.
- Counters are $clog2(BUF_DEPTH+1) bits wide.
- rvalid with outstanding = 0 is a protocol error: assertion fires and data is ignored.
- Reset mid-operation: all state clears immediately. Responses after rst_n rises are not expected; the memory is reset together with this block.

Decomposition:
- fetch_pkg holds:
  - fetch_state_t enum {IDLE, FETCH, DRAIN}.
  - RESET_PC_DEFAULT.
  - INSTR_NOP = 32'h00000013.
  - fetch_entry_t struct {pc, instr}.
- One sub-module, fetch_buffer: parameterised synchronous FIFO (push/pop/flush/full/empty/count) of fetch_entry_t.
- The address FIFO is a second instance of fetch_buffer.

Test Plan:
- Reset, rst_n released, memory with 1-cycle latency always granting:
  - No imem_req in the first cycle.
  - imem_addr sequence BFC00000, BFC00004, ...
  - InstrValidD first high 3 cycles after release, with PCD = BFC00000 and PCPlus4D = BFC00004.
- DecodeReady = 0 for 10 cycles:
  - imem_req drops once 2 entries are buffered or in flight.
  - No data lost; PCD order is preserved after DecodeReady = 1.
- Variable latency (1-4 cycles), then PCSrc pulse with PCTarget = 0x80000102 while 2 requests are in flight:
  - 2 responses dropped.
  - Next InstrValidD has PCD = 0x80000100.
- PCSrc coincident with imem_gnt at PCF = BFC00008:
  - Granted word discarded; next imem_addr = PCTarget.
  - InstrValidD is 0 in the PCSrc cycle.
- PCF = FFFFFFFC: next imem_addr = 00000000 and PCPlus4D of that instruction = 00000000.
- rst_n asserted mid-burst with a full buffer:
  - Outputs return immediately to reset values.
  - After release, fetch restarts at BFC00000.
